// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: data and occupancy
// widths, the IDLE/OWN state encoding, and the effective-occupancy helper.
package fifo_arb_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 7;
    localparam int OCC_W  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Occupancy including a write that is registered but not yet in the FIFO.
    // The result is one bit wider than the counter, so it cannot wrap.
    function automatic logic [OCC_W-1:0] occ_eff(input logic [CNT_W-1:0] cnt,
                                                 input logic             wr_en);
        return {1'b0, cnt} + {{(OCC_W-1){1'b0}}, wr_en};
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side signal bundle of the write-port arbiter.
// The master modport belongs to the producers and FIFO model; the slave
// modport belongs to the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = fifo_arb_pkg::DATA_W
);
    logic [N_REQ-1:0]              req;
    logic [N_REQ*DATA_W-1:0]       req_data;
    logic [N_REQ-1:0]              gnt;
    logic [fifo_arb_pkg::CNT_W-1:0] fifo_counter;
    logic                          fifo_wr_en;
    logic [DATA_W-1:0]             fifo_din;
    logic                          busy;

    modport master (
        output req, req_data, fifo_counter,
        input  gnt, fifo_wr_en, fifo_din, busy
    );

    modport slave (
        input  req, req_data, fifo_counter,
        output gnt, fifo_wr_en, fifo_din, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: starting one past last_winner and
// wrapping, returns the first requesting index as one-hot and binary.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0] last_winner,
    output logic [N_REQ-1:0] pick_oh,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_valid
);

    // Scan all N_REQ positions after last_winner and keep the first hit.
    always_comb begin
        pick_oh    = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            int j;
            j = (int'(last_winner) + k) % N_REQ;
            if (!pick_valid && req_vec[j]) begin
                pick_valid  = 1'b1;
                pick_oh[j]  = 1'b1;
                pick_idx    = IDX_W'(j);
            end else begin
                pick_valid = pick_valid;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of a 64-entry byte FIFO
// between N_REQ requesters. Grants are combinational; the FIFO write strobe
// and data are registered. Grants stop when the effective occupancy reaches
// DEPTH-HEADROOM.
// Optional feature macro: FIFO_ARB_BURST_EN -- a winner keeps the port for up
// to MAX_BURST back-to-back writes (IDLE/OWN FSM, busy=1 while owned).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int HEADROOM  = 0,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst_n,
    fifo_wr_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [OCC_W-1:0] SPACE_LIM = OCC_W'(DEPTH - HEADROOM);

    logic [IDX_W-1:0]  last_winner_r;
    logic              wr_en_r;
    logic [DATA_W-1:0] din_r;

    logic              space_ok_s;
    logic              keep_s;
    logic [N_REQ-1:0]  owner_oh_s;
    logic [IDX_W-1:0]  owner_idx_s;
    logic [N_REQ-1:0]  pick_oh_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_valid_s;
    logic [N_REQ-1:0]  gnt_s;
    logic [IDX_W-1:0]  gnt_idx_s;
    logic              xfer_s;

    assign space_ok_s = (occ_eff(bus.fifo_counter, wr_en_r) < SPACE_LIM);

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_vec     (bus.req),
        .last_winner (last_winner_r),
        .pick_oh     (pick_oh_s),
        .pick_idx    (pick_idx_s),
        .pick_valid  (pick_valid_s)
    );

`ifdef FIFO_ARB_BURST_EN
    localparam int BC_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_r;
    logic [IDX_W-1:0] owner_r;
    logic [BC_W-1:0]  burst_cnt_r;

    // The owner may continue only while it still requests, there is space
    // and its burst allowance is not used up.
    assign keep_s      = (state_r == OWN) && bus.req[owner_r] && space_ok_s &&
                         (burst_cnt_r < BC_W'(MAX_BURST));
    assign owner_oh_s  = {{(N_REQ-1){1'b0}}, 1'b1} << owner_r;
    assign owner_idx_s = owner_r;
    assign bus.busy    = (state_r == OWN);

    // Burst FSM: continue the current owner, or start a new burst from the
    // same-cycle round-robin winner, or fall back to IDLE when nothing moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            owner_r     <= '0;
            burst_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE, OWN: begin
                    if (keep_s) begin
                        state_r     <= OWN;
                        owner_r     <= owner_r;
                        burst_cnt_r <= burst_cnt_r + BC_W'(1);
                    end else if (xfer_s) begin
                        state_r     <= OWN;
                        owner_r     <= gnt_idx_s;
                        burst_cnt_r <= BC_W'(1);
                    end else begin
                        state_r     <= IDLE;
                        owner_r     <= owner_r;
                        burst_cnt_r <= '0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    owner_r     <= '0;
                    burst_cnt_r <= '0;
                end
            endcase
        end
    end
`else
    assign keep_s      = 1'b0;
    assign owner_oh_s  = '0;
    assign owner_idx_s = '0;
    assign bus.busy    = 1'b0;
`endif

    // Grant: held burst owner first, otherwise the round-robin winner when
    // there is space; nothing while reset is asserted.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = pick_idx_s;
        if (!rst_n) begin
            gnt_s = '0;
        end else if (keep_s) begin
            gnt_s     = owner_oh_s;
            gnt_idx_s = owner_idx_s;
        end else if (space_ok_s && pick_valid_s) begin
            gnt_s     = pick_oh_s;
            gnt_idx_s = pick_idx_s;
        end else begin
            gnt_s = '0;
        end
    end

    assign xfer_s  = |gnt_s;
    assign bus.gnt = gnt_s;

    // Output registers: one-cycle write strobe with the granted data, and
    // the round-robin pointer that advances on every transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r       <= 1'b0;
            din_r         <= '0;
            last_winner_r <= IDX_W'(N_REQ - 1);
        end else if (xfer_s) begin
            wr_en_r       <= 1'b1;
            din_r         <= bus.req_data[int'(gnt_idx_s)*DATA_W +: DATA_W];
            last_winner_r <= gnt_idx_s;
        end else begin
            wr_en_r       <= 1'b0;
            din_r         <= din_r;
            last_winner_r <= last_winner_r;
        end
    end

    assign bus.fifo_wr_en = wr_en_r;
    assign bus.fifo_din   = din_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: random requesters and a FIFO
// occupancy model, compared every cycle with a behavioural reference built
// from the arbitration rules, plus directed boundary scenarios.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N    = 4;
    localparam int MAXB = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(DATA_W)) bus ();
    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(DATA_W)) bus_hr ();

    fifo_wr_arbiter #(.N_REQ(N), .HEADROOM(0), .MAX_BURST(MAXB)) dut (
        .clk (clk), .rst_n (rst_n), .bus (bus.slave));
    fifo_wr_arbiter #(.N_REQ(N), .HEADROOM(4), .MAX_BURST(MAXB)) dut_hr (
        .clk (clk), .rst_n (rst_n), .bus (bus_hr.slave));

    logic [DATA_W-1:0] rdata [N];

    always_comb begin
        bus.req_data = '0;
        for (int i = 0; i < N; i++) bus.req_data[i*DATA_W +: DATA_W] = rdata[i];
    end

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int                m_lw;
    bit                m_wr;
    logic [DATA_W-1:0] m_din;
    bit                m_own;
    int                m_owner;
    int                m_bcnt;

    // stimulus controls and observation
    bit                emu;
    bit                rand_req;
    int                rd_pct;
    int                req_pct;
    int                n_gnt_obs;
    logic [N-1:0]      last_dut_gnt;
    logic [DATA_W-1:0] obs_din [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h time=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lw = N - 1; m_wr = 1'b0; m_din = '0; m_own = 1'b0; m_owner = 0; m_bcnt = 0;
    endtask

    // Expected grant from the rules: owner continuation, else first requester
    // after the last winner, only while occupancy + in-flight < DEPTH.
    task automatic model_gnt(output logic [N-1:0] g, output int gi, output bit kept);
        int occ;
        g = '0; gi = -1; kept = 1'b0;
        occ = int'(bus.fifo_counter) + (m_wr ? 1 : 0);
        if (rst_n && occ < DEPTH) begin
            if (m_own && bus.req[m_owner] && m_bcnt < MAXB) begin
                gi = m_owner; kept = 1'b1;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (gi < 0 && bus.req[(m_lw + k) % N]) gi = (m_lw + k) % N;
                end
            end
            if (gi >= 0) g[gi] = 1'b1;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] g;
        int gi;
        bit kept;
        bit obs_wr;
        int nc;
        @(negedge clk);
        model_gnt(g, gi, kept);
        check("gnt", bus.gnt, g);
        check("wr_en", bus.fifo_wr_en, m_wr);
        check("din", bus.fifo_din, m_din);
        check("busy", bus.busy, m_own);
        last_dut_gnt = bus.gnt;
        if (bus.gnt != '0) n_gnt_obs++;
        if (bus.fifo_wr_en) obs_din.push_back(bus.fifo_din);
        obs_wr = bus.fifo_wr_en;
        @(posedge clk);
        if (rst_n) begin
            m_wr = (gi >= 0);
            if (gi >= 0) begin
                m_din = rdata[gi];
                m_lw  = gi;
            end
            if (kept) m_bcnt++;
            else if (gi >= 0) begin m_own = BURST; m_owner = gi; m_bcnt = BURST ? 1 : 0; end
            else begin m_own = 1'b0; m_bcnt = 0; end
        end
        #1;
        if (emu) begin
            nc = int'(bus.fifo_counter) + (obs_wr ? 1 : 0);
            check("fifo_ovf", (nc > DEPTH), 1'b0);
            if (nc > DEPTH) nc = DEPTH;
            if (nc > 0 && int'($urandom_range(99)) < rd_pct) nc--;
            bus.fifo_counter = CNT_W'(nc);
        end
        if (rand_req) begin
            for (int i = 0; i < N; i++) begin
                if (g[i] || !bus.req[i]) begin
                    bus.req[i] = (int'($urandom_range(99)) < req_pct);
                    rdata[i]   = DATA_W'($urandom);
                end else if ($urandom_range(99) < 5) begin
                    bus.req[i] = 1'b0;
                end
            end
        end
    endtask

    // HEADROOM=4 instance: counter grows with each registered write.
    task automatic hr_cycles(input int n, output int grants);
        bit w;
        grants = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (bus_hr.gnt != '0) grants++;
            w = bus_hr.fifo_wr_en;
            @(posedge clk);
            #1;
            if (w) bus_hr.fifo_counter = bus_hr.fifo_counter + CNT_W'(1);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] exp2 [5];
        logic [DATA_W-1:0] exp6 [5];
        int hr_g;

        bus.req = '0; bus.fifo_counter = '0;
        bus_hr.req = '0; bus_hr.fifo_counter = '0; bus_hr.req_data = '0;
        for (int i = 0; i < N; i++) rdata[i] = '0;
        emu = 1'b0; rand_req = 1'b0; rd_pct = 0; req_pct = 50;
        model_reset();

        // reset state
        #1;
        check("rst_gnt", bus.gnt, 4'b0000);
        check("rst_wr_en", bus.fifo_wr_en, 1'b0);
        check("rst_din", bus.fifo_din, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        repeat (2) cycle();
        rst_n = 1'b1;

        // all requesting, empty FIFO: rotation 0,1,2,3,0 (or bursts of MAXB)
        for (int i = 0; i < N; i++) rdata[i] = DATA_W'(8'hA0 + i);
        bus.req = 4'b1111;
        obs_din.delete();
        repeat (6) cycle();
`ifdef FIFO_ARB_BURST_EN
        exp2 = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA1};
`else
        exp2 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
`endif
        check("t2_writes", obs_din.size(), 5);
        for (int i = 0; i < 5; i++) if (i < obs_din.size()) check("t2_din_seq", obs_din[i], exp2[i]);

`ifndef FIFO_ARB_BURST_EN
        // alternating pair after the rotation left last winner = 1
        bus.req = 4'b0101;
        obs_din.delete();
        repeat (5) cycle();
        exp6 = '{8'hA1, 8'hA2, 8'hA0, 8'hA2, 8'hA0};
        check("t6_writes", obs_din.size(), 5);
        for (int i = 0; i < 5; i++) if (i < obs_din.size()) check("t6_din_seq", obs_din[i], exp6[i]);
`endif

        // one free entry: exactly one grant, then the FIFO is full
        bus.req = '0;
        repeat (2) cycle();
        emu = 1'b1; rd_pct = 0;
        bus.fifo_counter = 7'd63;
        rdata[0] = 8'h55;
        bus.req = 4'b0001;
        n_gnt_obs = 0;
        repeat (6) cycle();
        check("t3_grants", n_gnt_obs, 1);
        check("t3_counter", bus.fifo_counter, 7'd64);
        rd_pct = 100;
        repeat (3) cycle();
        bus.req = '0;
        rd_pct = 0;
        repeat (2) cycle();

        // headroom instance: 60 blocks, 59 allows one grant only
        bus_hr.req_data = {8'h04, 8'h03, 8'h02, 8'h01};
        bus_hr.fifo_counter = 7'd60;
        bus_hr.req = 4'b0001;
        hr_cycles(5, hr_g);
        check("t4_at60_grants", hr_g, 0);
        bus_hr.fifo_counter = 7'd59;
        hr_cycles(6, hr_g);
        check("t4_at59_grants", hr_g, 1);
        check("t4_counter", bus_hr.fifo_counter, 7'd60);
        bus_hr.req = '0;

        // random traffic, FIFO filling then draining
        rand_req = 1'b1; req_pct = 60; rd_pct = 20;
        bus.fifo_counter = 7'd40;
        repeat (1500) cycle();

        // reset in the middle of traffic
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", bus.gnt, 4'b0000);
        check("mid_rst_wr_en", bus.fifo_wr_en, 1'b0);
        check("mid_rst_din", bus.fifo_din, 8'h00);
        check("mid_rst_busy", bus.busy, 1'b0);
        model_reset();
        rand_req = 1'b0;
        bus.req = 4'b1111;
        bus.fifo_counter = 7'd0;
        emu = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        check("first_gnt_after_rst", last_dut_gnt, 4'b0001);

        rand_req = 1'b1; emu = 1'b1; rd_pct = 70; req_pct = 40;
        repeat (1500) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
